// File: rtl/tl_mem_slave_if.sv
// Load/store bus between the master and tl_mem_slave: A-channel requests
// in, D-channel responses out, plus the slave's backpressure flag.
interface tl_mem_slave_if;
    logic        a_valid;
    logic [52:0] a_channel;
    logic        a_ready;
    logic        backpressureslave;
    logic        d_valid;
    logic        d_ready;
    logic [42:0] d_channel;
    logic        d_error;

    modport master (
        output a_valid, a_channel, d_ready,
        input  a_ready, backpressureslave, d_valid, d_channel, d_error
    );

    modport slave (
        input  a_valid, a_channel, d_ready,
        output a_ready, backpressureslave, d_valid, d_channel, d_error
    );
endinterface

// File: rtl/tl_mem_slave.sv
// Fixed-latency 1024x32 data memory behind a 2-entry request FIFO.
// Define TL_SLAVE_ERR_CHECK_EN to reject bad opcode/param/size requests.
module tl_mem_slave #(
    parameter int DEPTH_LOG2  = 10,
    parameter int MEM_LATENCY = 2
) (
    input logic           clk,
    input logic           reset,
    tl_mem_slave_if.slave bus
);
    localparam logic [2:0] OP_PUT   = 3'd0;
    localparam logic [2:0] OP_GET   = 3'd4;
    localparam logic [2:0] ACK      = 3'd0;
    localparam logic [2:0] ACK_DATA = 3'd1;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  param;
        logic [2:0]  size;
        logic [1:0]  source;
        logic [9:0]  addr;
        logic [31:0] data;
    } a_req_t;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  param;
        logic [2:0]  size;
        logic [1:0]  source;
        logic [31:0] data;
    } d_rsp_t;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                  state, state_nxt;
    a_req_t                  fifo_q [2];
    logic                    wr_ptr, rd_ptr;
    logic [1:0]              count;
    a_req_t                  work;
    logic [3:0]              lat_cnt;
    logic                    d_valid_q;
    d_rsp_t                  d_rsp_q;
    logic                    d_err_q;
    logic [31:0]             mem [2**DEPTH_LOG2];
    logic                    push, pop, exec;
    d_rsp_t                  rsp;
    logic                    err, wr_en;
    logic [DEPTH_LOG2-1:0]   addr;

    assign addr                  = work.addr[DEPTH_LOG2-1:0];
    assign bus.a_ready           = (count != 2'd2);
    assign bus.backpressureslave = (count == 2'd2);
    assign push                  = bus.a_valid && (count != 2'd2);
    assign bus.d_valid           = d_valid_q;
    assign bus.d_channel         = d_rsp_q;
    assign bus.d_error           = d_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        exec      = 1'b0;
        case (state)
            IDLE: if (count != 2'd0) begin
                pop       = 1'b1;
                state_nxt = BUSY;
            end
            BUSY: if (lat_cnt == 4'd0) begin
                exec      = 1'b1;
                state_nxt = RESP;
            end
            // d_valid is always high in RESP, so d_ready alone completes it
            RESP: if (bus.d_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage and memory array carry no reset; contents survive reset.
    always_ff @(posedge clk) begin
        if (push)           fifo_q[wr_ptr] <= bus.a_channel;
        if (exec && wr_en)  mem[addr]      <= work.data;
    end

    always_comb begin
        rsp        = '0;
        rsp.size   = work.size;
        rsp.source = work.source;
        err        = 1'b0;
        wr_en      = 1'b0;
`ifdef TL_SLAVE_ERR_CHECK_EN
        err = (work.opcode != OP_PUT && work.opcode != OP_GET) ||
              (work.param != 3'd0) || (work.size != 3'd5);
        if (work.opcode == OP_PUT) begin
            rsp.opcode = ACK;
            wr_en      = !err;
        end else if (work.opcode == OP_GET) begin
            rsp.opcode = ACK_DATA;
            rsp.data   = err ? 32'd0 : mem[addr];
        end
`else
        if (work.opcode == OP_PUT) begin
            rsp.opcode = ACK;
            wr_en      = 1'b1;
        end else begin
            rsp.opcode = ACK_DATA;
            rsp.data   = mem[addr];
        end
`endif
    end

`ifndef TL_SLAVE_ERR_CHECK_EN
    logic unused_param;
    assign unused_param = ^work.param;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            work      <= '0;
            lat_cnt   <= 4'd0;
            d_valid_q <= 1'b0;
            d_rsp_q   <= '0;
            d_err_q   <= 1'b0;
        end else begin
            if (pop) begin
                work    <= fifo_q[rd_ptr];
                lat_cnt <= 4'(MEM_LATENCY - 1);
            end else if (state == BUSY && lat_cnt != 4'd0) begin
                lat_cnt <= lat_cnt - 4'd1;
            end
            if (exec) begin
                d_rsp_q   <= rsp;
                d_err_q   <= err;
                d_valid_q <= 1'b1;
            end else if (state == RESP && bus.d_ready) begin
                d_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: doc/tl_mem_slave.md
# tl_mem_slave

Memory-side responder for the processor's load/store bus. It sits directly downstream of the load/store master: it accepts 53-bit A-channel requests (Get for `lw`, PutFullData for `sw`), buffers up to two in a request FIFO, and models a fixed-latency 1024×32 data memory. Each request produces a 43-bit D-channel response held until the master accepts it. It also drives `backpressureslave`, the stall signal the master samples before issuing.

## Interface
- `DEPTH_LOG2`, 10: memory address width; the array holds 1024 words.
- `MEM_LATENCY`, 2: memory cycles per request. Legal range is 1..15; 0 is illegal.
- `clk` input 1: the only clock; all logic is on its rising edge.
- `reset` input 1: asynchronous, active-high.
- `a_valid` input 1: request valid.
- `a_channel` input 53: `[52:50]` opcode, `[49:47]` param, `[46:44]` size, `[43:42]` source, `[41:32]` word address, `[31:0]` data.
- `a_ready` output 1: request FIFO is not full.
- `backpressureslave` output 1: request FIFO is full.
- `d_valid` output 1: response valid.
- `d_ready` input 1: master accepts the response.
- `d_channel` output 43: `[42:40]` opcode, `[39:37]` param (always 0), `[36:34]` size (echoed), `[33:32]` source (echoed), `[31:0]` data.
- `d_error` output 1: the request was rejected.

## Operation
- **Reset values:** `a_ready`=1, `backpressureslave`=0, `d_valid`=0, `d_channel`=0, `d_error`=0. FIFO is empty and the FSM is in IDLE. Memory contents are not reset.
- **Accept:** a request is pushed when `a_valid & a_ready` at a rising edge. The full 53-bit word is stored.
- **FIFO:** depth 2, 2-bit count.
  - `a_ready = (count != 2)`.
  - `backpressureslave = (count == 2)`.
  - Both outputs are driven from registered state.
  - A push and a pop in the same cycle leave the count unchanged.
- **FSM states:**
  - **IDLE:** if the FIFO is non-empty, pop the head into the working register, load `lat_cnt = MEM_LATENCY-1`, and go to BUSY.
  - **BUSY:** if `lat_cnt != 0`, decrement it. If `lat_cnt == 0`, execute the request, register the response, assert `d_valid`, and go to RESP.
  - **RESP:** hold `d_valid`, `d_channel` and `d_error` stable until `d_valid & d_ready`. At that edge, deassert `d_valid` and go to IDLE.
- **Execute rules:**
  - Opcode 4 (Get): `d_opcode`=1 (AccessAckData), `d_data = mem[addr]`.
  - Opcode 0 (PutFullData): `mem[addr] <= a_data`, `d_opcode`=0 (AccessAck), `d_data`=0.
  - Any other opcode: `d_opcode`=0, `d_data`=0, no memory access.
- **Error checks** (only with the macro, see Configuration): `d_error`=1 if any of these hold:
  - opcode is not 0 and not 4;
  - param ≠ 0;
  - size ≠ 5.

  An erroring request never writes memory and returns `d_data`=0.
- **Mid-operation reset:** clears the FIFO, FSM and response registers immediately. Queued and in-flight requests are dropped. Memory writes already committed persist.

## Timing
- Request accepted at edge E0, FIFO previously empty, FSM in IDLE: popped at E0+1, `d_valid` rises after edge E0+1+MEM_LATENCY. With the default latency this is 3 cycles after acceptance.
- Back-to-back requests: the next pop happens one cycle after the response handshake, because the FSM passes through IDLE.
  - Sustained throughput is one request per MEM_LATENCY+2 cycles, with `d_ready` held high.
- `d_ready` low: the FSM stays in RESP. The FIFO keeps filling; at 2 entries `a_ready` falls and `backpressureslave` rises in the cycle after the second push.
- Write-then-read to the same address: ordering is in request order. The Get observes the Put's data.

## Configuration
- **`TL_SLAVE_ERR_CHECK_EN` defined:** the error checks above are active.
- **Not defined:**
  - `d_error` is constant 0.
  - Unknown opcodes are executed as Get (AccessAckData with `mem[addr]`).
  - param and size are ignored, but size is still echoed in the response.

## Test plan
- **Reset:** assert `reset` asynchronously mid-cycle → all outputs take their reset values at once; `a_ready`=1 after release.
- **Write then read:** Put addr 0x005 data 0xDEADBEEF, then Get addr 0x005 → AccessAck (opcode 0, error 0), then AccessAckData with data 0xDEADBEEF. Each `d_valid` rises 3 cycles after its accept when `MEM_LATENCY`=2.
- **Backpressure:** hold `d_ready`=0 and issue 3 Gets → first enters BUSY/RESP, next two fill the FIFO, `backpressureslave`=1 and `a_ready`=0. Release `d_ready` → 3 responses in order, `backpressureslave` drops after the first pop.
- **Error (macro on):** opcode 3, then Put with size 2 to addr 0x010 → both responses `d_error`=1, `d_data`=0. A subsequent Get addr 0x010 returns the prior contents, showing the Put was blocked.
- **Error (macro off):** same stimulus → `d_error`=0; the size-2 Put writes memory.
- **Reset with requests in flight:** 2 requests queued and 1 in BUSY, then assert `reset` → no response emerges after release, the FIFO is empty, and memory written before the reset is intact.
